// File: rtl/s3edac_sched.sv
// Four-channel round-robin update scheduler for the Spartan-3E DAC driver.
// Optional build macro DACSCHED_SYNC_EN selects simultaneous-update command codes.
module s3edac_sched #(
   parameter int unsigned TIMEOUT = 127,
   parameter int unsigned OVRW    = 8
) (
   input  logic            dacclk,
   input  logic            dacrstn,
   input  logic [3:0]      chwr,
   input  logic [47:0]     chdata,
   output logic [3:0]      chpend,
   output logic [3:0]      chdone,
   output logic            busy,
   input  logic            errclr,
   output logic            dacerr,
   output logic [OVRW-1:0] ovrcnt,
   output logic            dacdav,
   input  logic            davdac,
   output logic [11:0]     dacdata,
   output logic [3:0]      dacaddr,
   output logic [3:0]      daccmd
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

   state_t          state, state_n;
   logic [11:0]     hold [4];
   logic [1:0]      ptr, sel, sel_c, idx;
   logic            found;
   logic [TW-1:0]   tcnt;
   logic [3:0]      cmd_c;
   logic            load, ack, tmo;
   logic [3:0]      ovr;
   logic [2:0]      ovr_pop;
   logic [OVRW:0]   ovr_sum;
   logic [OVRW-1:0] ovr_next;

   assign busy = (state != IDLE);

   // First pending channel at or after the pointer, wrapping modulo 4
   always_comb begin
      sel_c = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && chpend[idx]) begin
            sel_c = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
`ifdef DACSCHED_SYNC_EN
      cmd_c = ((chpend & ~(4'b0001 << sel_c)) != '0) ? 4'b0000 : 4'b0010;
`else
      cmd_c = 4'b0011;
`endif
   end

   always_comb begin
      ovr     = chwr & chpend;
      ovr_pop = '0;
      for (int unsigned i = 0; i < 4; i++)
         ovr_pop = ovr_pop + 3'(ovr[i]);
      ovr_sum  = {1'b0, ovrcnt} + (OVRW + 1)'(ovr_pop);
      ovr_next = ovr_sum[OVRW] ? '1 : ovr_sum[OVRW-1:0];
   end

   always_ff @(posedge dacclk or negedge dacrstn) begin
      if (!dacrstn) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      ack     = 1'b0;
      tmo     = 1'b0;
      case (state)
         IDLE: begin
            if (chpend != '0) begin
               load    = 1'b1;
               state_n = SEND;
            end
         end
         SEND: begin
            if (davdac) begin
               ack     = 1'b1;
               state_n = RELEASE;
            end else if (tcnt == TLAST) begin
               tmo     = 1'b1;
               state_n = RELEASE;
            end
         end
         RELEASE: begin
            if (!davdac) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge dacclk or negedge dacrstn) begin
      if (!dacrstn) begin
         for (int unsigned i = 0; i < 4; i++) hold[i] <= '0;
         chpend  <= '0;
         chdone  <= '0;
         dacerr  <= 1'b0;
         ovrcnt  <= '0;
         ptr     <= '0;
         sel     <= '0;
         tcnt    <= '0;
         dacdav  <= 1'b0;
         dacdata <= '0;
         dacaddr <= '0;
         daccmd  <= 4'b0011;
      end else begin
         for (int unsigned i = 0; i < 4; i++)
            if (chwr[i]) hold[i] <= chdata[12*i +: 12];
         // A write landing on the ACK edge keeps the channel pending
         chpend <= (chpend & ~(ack ? (4'b0001 << sel) : 4'b0000)) | chwr;
         ovrcnt <= ovr_next;
         chdone <= ack ? (4'b0001 << sel) : 4'b0000;
         if (ack) ptr <= sel + 2'd1;
         if (load) begin
            sel     <= sel_c;
            dacdata <= hold[sel_c];
            dacaddr <= {2'b00, sel_c};
            daccmd  <= cmd_c;
            dacdav  <= 1'b1;
            tcnt    <= '0;
         end else if (ack || tmo) begin
            dacdav  <= 1'b0;
         end else if (state == SEND) begin
            tcnt    <= tcnt + 1'b1;
         end
         if (tmo)         dacerr <= 1'b1;
         else if (errclr) dacerr <= 1'b0;
      end
   end

endmodule

// File: tb/tb_s3edac_sched.sv
// Scoreboard bench for s3edac_sched: stimulus queues expected frames/acks,
// monitor compares them as the DUT presents them.
module tb_s3edac_sched;

   localparam int unsigned TIMEOUT = 127;
   localparam int unsigned OVRW    = 8;
   localparam int unsigned ACK_DLY = 51;

   logic            dacclk = 1'b0;
   logic            dacrstn;
   logic [3:0]      chwr;
   logic [47:0]     chdata;
   logic [3:0]      chpend, chdone;
   logic            busy, errclr, dacerr;
   logic [OVRW-1:0] ovrcnt;
   logic            dacdav, davdac;
   logic [11:0]     dacdata;
   logic [3:0]      dacaddr, daccmd;

   int checks = 0;
   int errors = 0;
   bit ack_en = 1'b1;

   logic [19:0] frame_q [$];
   logic [3:0]  done_q  [$];

   s3edac_sched #(.TIMEOUT(TIMEOUT), .OVRW(OVRW)) dut (
      .dacclk(dacclk), .dacrstn(dacrstn), .chwr(chwr), .chdata(chdata),
      .chpend(chpend), .chdone(chdone), .busy(busy), .errclr(errclr),
      .dacerr(dacerr), .ovrcnt(ovrcnt), .dacdav(dacdav), .davdac(davdac),
      .dacdata(dacdata), .dacaddr(dacaddr), .daccmd(daccmd)
   );

   always #5 dacclk = ~dacclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] exp_cmd(input bit others);
`ifdef DACSCHED_SYNC_EN
      return others ? 4'b0000 : 4'b0010;
`else
      return 4'b0011;
`endif
   endfunction

   function automatic logic [19:0] frm(input int unsigned ch, input logic [11:0] d, input bit others);
      return {4'(ch), d, exp_cmd(others)};
   endfunction

   // Driver model: ACKs for one cycle after ACK_DLY cycles of dacdav
   initial begin
      int unsigned cnt = 0;
      davdac = 1'b0;
      forever begin
         @(negedge dacclk);
         if (davdac) begin
            davdac = 1'b0;
            cnt = 0;
         end else if (dacdav && ack_en) begin
            cnt++;
            if (cnt == ACK_DLY) davdac = 1'b1;
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor
   initial begin
      logic        prev_dav = 1'b0;
      logic        unstable = 1'b0;
      logic [19:0] cur = '0;
      logic [19:0] e;
      forever begin
         @(negedge dacclk);
         if (dacrstn) begin
            if (dacdav && !prev_dav) begin
               cur = {dacaddr, dacdata, daccmd};
               if (frame_q.size() == 0) check("frame_unexpected", {12'h0, cur}, 32'h0);
               else begin
                  e = frame_q.pop_front();
                  check("frame", {12'h0, cur}, {12'h0, e});
               end
            end else if (dacdav && ({dacaddr, dacdata, daccmd} !== cur)) begin
               unstable = 1'b1;
            end
            if (!dacdav && prev_dav) begin
               check("frame_stable", {31'h0, unstable}, 32'h0);
               unstable = 1'b0;
            end
            if (chdone != 4'h0) begin
               if (done_q.size() == 0) check("chdone_unexpected", {28'h0, chdone}, 32'h0);
               else check("chdone", {28'h0, chdone}, {28'h0, done_q.pop_front()});
            end
         end
         prev_dav = dacdav;
      end
   end

   task automatic post(input logic [3:0] mask, input logic [47:0] d);
      @(negedge dacclk);
      chwr = mask;
      chdata = d;
      @(negedge dacclk);
      chwr = '0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 2000; i++) begin
         @(negedge dacclk);
         if (!busy && chpend == 4'h0) return;
      end
      check(name, 32'h0, 32'h1);
   endtask

   task automatic wait_dav(input string name);
      for (int i = 0; i < 100; i++) begin
         if (dacdav) return;
         @(negedge dacclk);
      end
      check(name, 32'h0, 32'h1);
   endtask

   task automatic do_reset();
      @(negedge dacclk);
      dacrstn = 1'b0;
      repeat (2) @(negedge dacclk);
      dacrstn = 1'b1;
   endtask

   initial begin
      int n;
      dacrstn = 1'b0;
      chwr    = '0;
      chdata  = '0;
      errclr  = 1'b0;
      repeat (3) @(negedge dacclk);
      check("rst_dacdav", {31'h0, dacdav}, 32'h0);
      check("rst_chpend", {28'h0, chpend}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_dacerr", {31'h0, dacerr}, 32'h0);
      check("rst_ovrcnt", {24'h0, ovrcnt}, 32'h0);
      check("rst_outs", {12'h0, dacaddr, dacdata, daccmd}, 32'h0_0003);
      dacrstn = 1'b1;

      // Single write to B
      frame_q.push_back(frm(1, 12'hABC, 1'b0));
      done_q.push_back(4'b0010);
      post(4'b0010, {24'h0, 12'hABC, 12'h0});
      check("lat_pend", {28'h0, chpend}, 32'h2);
      check("lat_dav0", {31'h0, dacdav}, 32'h0);
      @(negedge dacclk);
      check("lat_dav1", {31'h0, dacdav}, 32'h1);
      wait_idle("idle_t1");
      check("t1_pend", {28'h0, chpend}, 32'h0);

      // Four simultaneous writes from pointer A
      do_reset();
      frame_q.push_back(frm(0, 12'h111, 1'b1));
      frame_q.push_back(frm(1, 12'h222, 1'b1));
      frame_q.push_back(frm(2, 12'h333, 1'b1));
      frame_q.push_back(frm(3, 12'h444, 1'b0));
      done_q.push_back(4'b0001);
      done_q.push_back(4'b0010);
      done_q.push_back(4'b0100);
      done_q.push_back(4'b1000);
      post(4'b1111, {12'h444, 12'h333, 12'h222, 12'h111});
      wait_idle("idle_t2");

      // Coalescing on C while A is in service, then a write on the ACK edge
      frame_q.push_back(frm(0, 12'hAAA, 1'b0));
      done_q.push_back(4'b0001);
      post(4'b0001, {36'h0, 12'hAAA});
      wait_dav("dav_t3");
      frame_q.push_back(frm(2, 12'h0F0, 1'b0));
      done_q.push_back(4'b0100);
      post(4'b0100, {12'h0, 12'h5A5, 24'h0});
      post(4'b0100, {12'h0, 12'h0F0, 24'h0});
      check("ovrcnt_1", {24'h0, ovrcnt}, 32'h1);
      n = 0;
      while (n < 400) begin
         @(negedge dacclk);
         #1;
         if (davdac && dacdav && dacaddr == 4'd2) break;
         n++;
      end
      check("ack_c_seen", {31'h0, (n < 400)}, 32'h1);
      frame_q.push_back(frm(2, 12'h777, 1'b0));
      done_q.push_back(4'b0100);
      chwr = 4'b0100;
      chdata = {12'h0, 12'h777, 24'h0};
      @(negedge dacclk);
      chwr = '0;
      check("ackedge_pend", {28'h0, chpend}, 32'h4);
      wait_idle("idle_t3");

      // Timeout with no ACK, then retry succeeds
      ack_en = 1'b0;
      frame_q.push_back(frm(1, 12'h123, 1'b0));
      frame_q.push_back(frm(1, 12'h123, 1'b0));
      done_q.push_back(4'b0010);
      post(4'b0010, {24'h0, 12'h123, 12'h0});
      wait_dav("dav_t4");
      n = 0;
      while (dacdav && n < 400) begin
         n++;
         @(negedge dacclk);
      end
      check("tmo_cycles", 32'(n), 32'(TIMEOUT));
      check("tmo_err", {31'h0, dacerr}, 32'h1);
      check("tmo_pend", {28'h0, chpend}, 32'h2);
      ack_en = 1'b1;
      wait_idle("idle_t4");
      check("err_sticky", {31'h0, dacerr}, 32'h1);
      errclr = 1'b1;
      @(negedge dacclk);
      errclr = 1'b0;
      check("err_clr", {31'h0, dacerr}, 32'h0);

      // Asynchronous reset during SEND
      frame_q.push_back(frm(3, 12'h456, 1'b0));
      post(4'b1000, {12'h456, 36'h0});
      wait_dav("dav_t5");
      repeat (5) @(negedge dacclk);
      #2 dacrstn = 1'b0;
      #1;
      check("arst_dav", {31'h0, dacdav}, 32'h0);
      check("arst_pend", {28'h0, chpend}, 32'h0);
      check("arst_busy", {31'h0, busy}, 32'h0);
      check("arst_ovr", {24'h0, ovrcnt}, 32'h0);
      @(negedge dacclk);
      dacrstn = 1'b1;
      repeat (3) @(negedge dacclk);

      check("frames_left", 32'(frame_q.size()), 32'h0);
      check("dones_left", 32'(done_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
